// File: rtl/btn_evt_pkg.sv
// Shared constants and types for the button event scheduler.
package btn_evt_pkg;

   // Hold counter width; LONG_CYC / REPEAT_CYC are compared at this width.
   localparam int unsigned CNT_W = 24;

   // Event type encodings on the evt_type port.
   localparam logic [1:0] EVT_PRESS   = 2'd0;
   localparam logic [1:0] EVT_RELEASE = 2'd1;
   localparam logic [1:0] EVT_LONG    = 2'd2;
   localparam logic [1:0] EVT_REPEAT  = 2'd3;

   // Per-button press/hold state.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HELD = 2'd1,
      ST_LONG = 2'd2
   } btn_state_e;

endpackage

// File: rtl/btn_hold_fsm.sv
// Press/hold state machine for a single debounced button. Emits a one-cycle
// event strobe (emit/emit_type) that the top loads into the pending slot.
module btn_hold_fsm
   import btn_evt_pkg::*;
#(
   parameter logic [CNT_W-1:0] LONG_CYC   = 24'd6000000,
   parameter logic [CNT_W-1:0] REPEAT_CYC = 24'd1500000,
   parameter bit               REPEAT_EN  = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       level,
   output logic       emit,
   output logic [1:0] emit_type
);

   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LONG_LAST   = LONG_CYC - CNT_ONE;
   localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_CYC - CNT_ONE;

   logic             btn_q;
   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Edge register, state and hold counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_q   <= 1'b0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         btn_q   <= level;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, counter update and event strobe; release beats LONG/REPEAT.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      emit      = 1'b0;
      emit_type = EVT_PRESS;
      unique case (state_q)
         ST_IDLE: begin
            // Only a fresh rising edge starts a hold.
            if (level && !btn_q) begin
               emit      = 1'b1;
               emit_type = EVT_PRESS;
               cnt_d     = '0;
               state_d   = ST_HELD;
            end
         end
         ST_HELD: begin
            if (!level) begin
               emit      = 1'b1;
               emit_type = EVT_RELEASE;
               state_d   = ST_IDLE;
            end else if (cnt_q == LONG_LAST) begin
               emit      = 1'b1;
               emit_type = EVT_LONG;
               cnt_d     = '0;
               state_d   = ST_LONG;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_LONG: begin
            if (!level) begin
               emit      = 1'b1;
               emit_type = EVT_RELEASE;
               state_d   = ST_IDLE;
            end else if (REPEAT_EN && (cnt_q == REPEAT_LAST)) begin
               emit      = 1'b1;
               emit_type = EVT_REPEAT;
               cnt_d     = '0;
            end else if (cnt_q != CNT_MAX) begin
               // Saturate so a long hold with repeats disabled never wraps.
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/button_event_ctrl.sv
// Button event scheduler: one hold FSM per button, a one-deep pending slot per
// button, and a round-robin arbiter feeding a single valid/ready event port.
module button_event_ctrl
   import btn_evt_pkg::*;
#(
   parameter int unsigned      N_BTN      = 4,
   parameter logic [CNT_W-1:0] LONG_CYC   = 24'd6000000,
   parameter logic [CNT_W-1:0] REPEAT_CYC = 24'd1500000,
   parameter bit               REPEAT_EN  = 1'b1,
   localparam int unsigned     BW         = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_level,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [BW-1:0]    evt_btn,
   output logic [1:0]       evt_type,
   output logic             ovf,
   input  logic             ovf_clr
);

   logic [N_BTN-1:0]      emit;
   logic [N_BTN-1:0][1:0] emit_type;

   logic [N_BTN-1:0]      pend_v_q, pend_v_d;
   logic [N_BTN-1:0][1:0] pend_type_q, pend_type_d;

   logic [BW-1:0] rr_ptr_q, rr_ptr_d;
   logic          evt_valid_q, evt_valid_d;
   logic [BW-1:0] evt_btn_q, evt_btn_d;
   logic [1:0]    evt_type_q, evt_type_d;
   logic          ovf_q, ovf_d;

   logic          free;
   logic          grant_v;
   logic [BW-1:0] grant_idx;
   logic          drop;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_hold_fsm #(
         .LONG_CYC   (LONG_CYC),
         .REPEAT_CYC (REPEAT_CYC),
         .REPEAT_EN  (REPEAT_EN)
      ) u_fsm (
         .clk       (clk),
         .rst_n     (rst_n),
         .level     (btn_level[i]),
         .emit      (emit[i]),
         .emit_type (emit_type[i])
      );
   end

   // Output register may load when empty or being consumed this cycle.
   assign free = !evt_valid_q || evt_ready;

   // Round-robin search: first pending slot at or after rr_ptr, with wrap.
   always_comb begin
      logic [BW-1:0] idx;
      grant_v   = 1'b0;
      grant_idx = '0;
      idx       = '0;
      for (int k = 0; k < int'(N_BTN); k++) begin
         idx = BW'((int'(rr_ptr_q) + k) % int'(N_BTN));
         if (free && !grant_v && pend_v_q[idx]) begin
            grant_v   = 1'b1;
            grant_idx = idx;
         end
      end
   end

   // Pending slots: load new events, clear on grant, drop when still occupied.
   always_comb begin
      logic granted;
      pend_v_d    = pend_v_q;
      pend_type_d = pend_type_q;
      drop        = 1'b0;
      granted     = 1'b0;
      for (int i = 0; i < int'(N_BTN); i++) begin
         granted = grant_v && (grant_idx == BW'(i));
         if (emit[i]) begin
            if (pend_v_q[i] && !granted) begin
               // Keep the older event; the new one is lost.
               drop = 1'b1;
            end else begin
               pend_v_d[i]    = 1'b1;
               pend_type_d[i] = emit_type[i];
            end
         end else if (granted) begin
            pend_v_d[i] = 1'b0;
         end
      end
   end

   // Output register, round-robin pointer and sticky overflow.
   always_comb begin
      evt_valid_d = evt_valid_q;
      evt_btn_d   = evt_btn_q;
      evt_type_d  = evt_type_q;
      rr_ptr_d    = rr_ptr_q;
      if (free) begin
         if (grant_v) begin
            evt_valid_d = 1'b1;
            evt_btn_d   = grant_idx;
            evt_type_d  = pend_type_q[grant_idx];
            if ((int'(grant_idx) + 1) >= int'(N_BTN)) begin
               rr_ptr_d = '0;
            end else begin
               rr_ptr_d = grant_idx + BW'(1);
            end
         end else begin
            evt_valid_d = 1'b0;
         end
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // State registers for slots, arbiter and output port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_v_q    <= '0;
         pend_type_q <= '0;
         rr_ptr_q    <= '0;
         evt_valid_q <= 1'b0;
         evt_btn_q   <= '0;
         evt_type_q  <= EVT_PRESS;
         ovf_q       <= 1'b0;
      end else begin
         pend_v_q    <= pend_v_d;
         pend_type_q <= pend_type_d;
         rr_ptr_q    <= rr_ptr_d;
         evt_valid_q <= evt_valid_d;
         evt_btn_q   <= evt_btn_d;
         evt_type_q  <= evt_type_d;
         ovf_q       <= ovf_d;
      end
   end

   assign evt_valid = evt_valid_q;
   assign evt_btn   = evt_btn_q;
   assign evt_type  = evt_type_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with short LONG/REPEAT periods.
// A second instance with repeats disabled shares all inputs.
module tb_button_event_ctrl;
   import btn_evt_pkg::*;

   localparam int unsigned N_BTN = 4;
   localparam int unsigned BW    = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N_BTN-1:0] btn_level;
   logic             evt_ready;
   logic             ovf_clr;

   logic             evt_valid, evt_valid_b;
   logic [BW-1:0]    evt_btn, evt_btn_b;
   logic [1:0]       evt_type, evt_type_b;
   logic             ovf, ovf_b;

   int n_checks = 0;
   int n_errors = 0;

   button_event_ctrl #(
      .N_BTN      (N_BTN),
      .LONG_CYC   (24'd8),
      .REPEAT_CYC (24'd4),
      .REPEAT_EN  (1'b1)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_level (btn_level),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_btn   (evt_btn),
      .evt_type  (evt_type),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   button_event_ctrl #(
      .N_BTN      (N_BTN),
      .LONG_CYC   (24'd8),
      .REPEAT_CYC (24'd4),
      .REPEAT_EN  (1'b0)
   ) u_dut_norep (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_level (btn_level),
      .evt_valid (evt_valid_b),
      .evt_ready (evt_ready),
      .evt_btn   (evt_btn_b),
      .evt_type  (evt_type_b),
      .ovf       (ovf_b),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_evt(input string tag, input bit v, input int b, input int t);
      check_eq({tag, ".valid"}, 32'(evt_valid), 32'(v));
      if (v) begin
         check_eq({tag, ".btn"}, 32'(evt_btn), b);
         check_eq({tag, ".type"}, 32'(evt_type), t);
      end
   endtask

   // Advance one clock and check the event port.
   task automatic step(input string tag, input bit v, input int b, input int t);
      tick();
      expect_evt(tag, v, b, t);
   endtask

   initial begin
      int exp_t;
      rst_n     = 1'b0;
      btn_level = '0;
      evt_ready = 1'b1;
      ovf_clr   = 1'b0;
      tick();
      tick();
      check_eq("rst.valid", 32'(evt_valid), 0);
      check_eq("rst.btn", 32'(evt_btn), 0);
      check_eq("rst.type", 32'(evt_type), 0);
      check_eq("rst.ovf", 32'(ovf), 0);
      rst_n = 1'b1;

      // PRESS/RELEASE on button 2, held for three edges.
      btn_level = 4'b0100;
      step("pr.s1", 0, 0, 0);
      step("pr.s2", 1, 2, EVT_PRESS);
      step("pr.s3", 0, 0, 0);
      btn_level = 4'b0000;
      step("pr.s4", 0, 0, 0);
      step("pr.s5", 1, 2, EVT_RELEASE);
      step("pr.s6", 0, 0, 0);
      check_eq("pr.ovf", 32'(ovf), 0);

      // LONG/REPEAT on button 0 held for 20 edges; release beats a due REPEAT.
      btn_level = 4'b0001;
      for (int s = 1; s <= 24; s++) begin
         tick();
         case (s)
            2:       exp_t = EVT_PRESS;
            10:      exp_t = EVT_LONG;
            14, 18:  exp_t = EVT_REPEAT;
            22:      exp_t = EVT_RELEASE;
            default: exp_t = -1;
         endcase
         expect_evt($sformatf("lr.s%0d", s), exp_t >= 0, 0, exp_t);
         if (exp_t == EVT_REPEAT) exp_t = -1;
         check_eq($sformatf("norep.s%0d.valid", s), 32'(evt_valid_b), 32'(exp_t >= 0));
         if (exp_t >= 0) check_eq($sformatf("norep.s%0d.type", s), 32'(evt_type_b), exp_t);
         if (s == 20) btn_level = 4'b0000;
      end

      // Simultaneous edges from a freshly reset pointer.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      btn_level = 4'b1011;
      step("sim.s1", 0, 0, 0);
      step("sim.s2", 1, 0, EVT_PRESS);
      step("sim.s3", 1, 1, EVT_PRESS);
      step("sim.s4", 1, 3, EVT_PRESS);
      btn_level = 4'b0000;
      step("sim.s5", 0, 0, 0);
      step("sim.s6", 1, 0, EVT_RELEASE);
      step("sim.s7", 1, 1, EVT_RELEASE);
      step("sim.s8", 1, 3, EVT_RELEASE);
      step("sim.s9", 0, 0, 0);
      // Pointer moves to 2 after btn 1, so btn 3 wins over btn 0.
      btn_level = 4'b0010;
      step("rr.s10", 0, 0, 0);
      step("rr.s11", 1, 1, EVT_PRESS);
      btn_level = 4'b1011;
      step("rr.s12", 0, 0, 0);
      step("rr.s13", 1, 3, EVT_PRESS);
      step("rr.s14", 1, 0, EVT_PRESS);
      step("rr.s15", 0, 0, 0);
      btn_level = 4'b0000;
      step("rr.s16", 0, 0, 0);
      step("rr.s17", 1, 1, EVT_RELEASE);
      step("rr.s18", 1, 3, EVT_RELEASE);
      step("rr.s19", 1, 0, EVT_RELEASE);
      step("rr.s20", 0, 0, 0);

      // Backpressure: btn 2 PRESS stalls the port, btn 1 RELEASE is dropped.
      evt_ready = 1'b0;
      btn_level = 4'b0100;
      step("bp.s1", 0, 0, 0);
      step("bp.s2", 1, 2, EVT_PRESS);
      btn_level = 4'b0110;
      step("bp.s3", 1, 2, EVT_PRESS);
      check_eq("bp.s3.ovf", 32'(ovf), 0);
      btn_level = 4'b0100;
      step("bp.s4", 1, 2, EVT_PRESS);
      check_eq("bp.s4.ovf", 32'(ovf), 1);
      step("bp.s5", 1, 2, EVT_PRESS);
      check_eq("bp.s5.ovf", 32'(ovf), 1);
      ovf_clr = 1'b1;
      step("bp.s6", 1, 2, EVT_PRESS);
      check_eq("bp.s6.ovf", 32'(ovf), 0);
      ovf_clr   = 1'b0;
      evt_ready = 1'b1;
      step("bp.s7", 1, 1, EVT_PRESS);
      step("bp.s8", 0, 0, 0);
      btn_level = 4'b0000;
      step("bp.s9", 0, 0, 0);
      step("bp.s10", 1, 2, EVT_RELEASE);
      step("bp.s11", 0, 0, 0);
      // Drop and clear in the same cycle: the flag stays set.
      evt_ready = 1'b0;
      btn_level = 4'b1000;
      step("sw.s12", 0, 0, 0);
      step("sw.s13", 1, 3, EVT_PRESS);
      btn_level = 4'b1001;
      step("sw.s14", 1, 3, EVT_PRESS);
      btn_level = 4'b1000;
      ovf_clr   = 1'b1;
      step("sw.s15", 1, 3, EVT_PRESS);
      check_eq("sw.s15.ovf", 32'(ovf), 1);
      step("sw.s16", 1, 3, EVT_PRESS);
      check_eq("sw.s16.ovf", 32'(ovf), 0);
      ovf_clr   = 1'b0;
      evt_ready = 1'b1;
      step("sw.s17", 1, 0, EVT_PRESS);
      btn_level = 4'b0000;
      step("sw.s18", 0, 0, 0);
      step("sw.s19", 1, 3, EVT_RELEASE);
      step("sw.s20", 0, 0, 0);

      // Grant-and-refill: RELEASE arrives as the pending PRESS is granted.
      btn_level = 4'b0001;
      step("gr.s1", 0, 0, 0);
      btn_level = 4'b0000;
      step("gr.s2", 1, 0, EVT_PRESS);
      check_eq("gr.s2.ovf", 32'(ovf), 0);
      step("gr.s3", 1, 0, EVT_RELEASE);
      check_eq("gr.s3.ovf", 32'(ovf), 0);
      step("gr.s4", 0, 0, 0);

      // Reset mid-hold with the counter at 5; button still high afterwards.
      btn_level = 4'b0100;
      step("rh.s1", 0, 0, 0);
      step("rh.s2", 1, 2, EVT_PRESS);
      for (int s = 3; s <= 6; s++) step($sformatf("rh.s%0d", s), 0, 0, 0);
      rst_n = 1'b0;
      #1;
      check_eq("rh.rst.valid", 32'(evt_valid), 0);
      check_eq("rh.rst.btn", 32'(evt_btn), 0);
      check_eq("rh.rst.type", 32'(evt_type), 0);
      check_eq("rh.rst.ovf", 32'(ovf), 0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int s = 1; s <= 10; s++) begin
         tick();
         case (s)
            2:       exp_t = EVT_PRESS;
            10:      exp_t = EVT_LONG;
            default: exp_t = -1;
         endcase
         expect_evt($sformatf("rh.p%0d", s), exp_t >= 0, 2, exp_t);
      end
      btn_level = 4'b0000;
      step("rh.p11", 0, 0, 0);
      step("rh.p12", 1, 2, EVT_RELEASE);
      step("rh.p13", 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
